// File: rtl/soc_system_nco_clkgen.sv
// soc_system_nco_clkgen
// Multi-channel numerically-controlled clock generator. Each channel owns a
// phase accumulator that advances by a programmable increment every refclk
// edge; the accumulator MSB is the channel clock and the carry out of the add
// becomes a one-cycle tick strobe. A shared lock counter reports when the
// configuration has been left alone for LOCK_CYCLES edges.

module soc_system_nco_clkgen #(
  parameter int NUM_CH      = 4,
  parameter int ACC_W       = 32,
  parameter int LOCK_CYCLES = 16,
  parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              cfg_wr,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  input  logic [ACC_W-1:0]  cfg_phase,
  input  logic              cfg_en,
  input  logic              sync_load,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic              locked
);

  localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);
  localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_CYCLES);

  // A write to a channel number beyond NUM_CH must not disturb anything,
  // including the lock counter, so every consumer looks at this qualified strobe.
  logic cfg_valid;
  assign cfg_valid = cfg_wr && ({1'b0, cfg_ch} < (CH_W + 1)'(NUM_CH));

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] inc;
    logic [ACC_W-1:0] phase;
    logic             en;
    logic             tick_q;
    logic             sel;
    logic [ACC_W:0]   sum;

    assign sel = cfg_valid && (cfg_ch == CH_W'(g));
    assign sum = {1'b0, acc} + {1'b0, inc};

    // Channel state: a write takes priority over sync_load so the written
    // channel lands on the new phase while the others reload their stored one.
    // The carry of the single add is registered straight into tick.
    always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
        acc    <= '0;
        inc    <= '0;
        phase  <= '0;
        en     <= 1'b0;
        tick_q <= 1'b0;
      end else if (sel) begin
        inc    <= cfg_inc;
        phase  <= cfg_phase;
        en     <= cfg_en;
        acc    <= cfg_phase;
        tick_q <= 1'b0;
      end else if (sync_load) begin
        acc    <= phase;
        tick_q <= 1'b0;
      end else if (en) begin
        acc    <= sum[ACC_W-1:0];
        tick_q <= sum[ACC_W];
      end else begin
        tick_q <= 1'b0;
      end
    end

    assign clk_out[g] = acc[ACC_W-1];
    assign tick[g]    = tick_q;
  end

  logic [LOCK_W-1:0] lock_cnt;

  // Lock counter: restarts on any reconfiguration or realignment and
  // saturates once the configuration has been quiet long enough.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      lock_cnt <= '0;
    end else if (cfg_valid || sync_load) begin
      lock_cnt <= '0;
    end else if (lock_cnt != LOCK_MAX) begin
      lock_cnt <= lock_cnt + 1'b1;
    end
  end

  assign locked = (lock_cnt == LOCK_MAX);

endmodule

// File: tb/tb_soc_system_nco_clkgen.sv
// Self-checking bench for soc_system_nco_clkgen (3 channels, 8-bit
// accumulators, lock after 4 quiet edges). An arithmetic reference model
// tracks every channel; table vectors and hand-written sequences add
// tick-count, alignment and lock-timing checks.

module tb_soc_system_nco_clkgen;

  localparam int NUM_CH      = 3;
  localparam int ACC_W       = 8;
  localparam int LOCK_CYCLES = 4;
  localparam int CH_W        = 2;
  localparam int MOD         = 256;

  logic              refclk = 1'b0;
  logic              rst;
  logic              cfg_wr;
  logic [CH_W-1:0]   cfg_ch;
  logic [ACC_W-1:0]  cfg_inc;
  logic [ACC_W-1:0]  cfg_phase;
  logic              cfg_en;
  logic              sync_load;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;
  logic              locked;

  int vectors     = 0;
  int miscompares = 0;

  int m_acc   [NUM_CH];
  int m_inc   [NUM_CH];
  int m_phase [NUM_CH];
  int m_en    [NUM_CH];
  int m_tick  [NUM_CH];
  int m_lock;

  typedef struct {
    int ch;
    int inc;
    int phase;
    int en;
    int cycles;
    int exp_ticks;
    int exp_high;
  } vec_t;

  vec_t vec_tbl [5];

  soc_system_nco_clkgen #(
    .NUM_CH(NUM_CH),
    .ACC_W(ACC_W),
    .LOCK_CYCLES(LOCK_CYCLES)
  ) dut (
    .refclk(refclk),
    .rst(rst),
    .cfg_wr(cfg_wr),
    .cfg_ch(cfg_ch),
    .cfg_inc(cfg_inc),
    .cfg_phase(cfg_phase),
    .cfg_en(cfg_en),
    .sync_load(sync_load),
    .clk_out(clk_out),
    .tick(tick),
    .locked(locked)
  );

  // 10-unit reference clock
  always #5 refclk = ~refclk;

  task automatic checkValue(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_acc[c] = 0; m_inc[c] = 0; m_phase[c] = 0; m_en[c] = 0; m_tick[c] = 0;
    end
    m_lock = 0;
  endtask

  // Behavioural view: accumulate modulo 2^8, a tick whenever the sum wraps
  task automatic modelStep(input int wr, input int ch, input int inc, input int phase,
                           input int en, input int sync);
    int s;
    for (int c = 0; c < NUM_CH; c++) begin
      if (wr != 0 && ch == c) begin
        m_inc[c] = inc; m_phase[c] = phase; m_en[c] = en;
        m_acc[c] = phase; m_tick[c] = 0;
      end else if (sync != 0) begin
        m_acc[c] = m_phase[c]; m_tick[c] = 0;
      end else if (m_en[c] != 0) begin
        s = m_acc[c] + m_inc[c];
        m_tick[c] = (s >= MOD) ? 1 : 0;
        m_acc[c] = s % MOD;
      end else begin
        m_tick[c] = 0;
      end
    end
    if ((wr != 0 && ch < NUM_CH) || sync != 0) m_lock = 0;
    else if (m_lock < LOCK_CYCLES) m_lock = m_lock + 1;
  endtask

  task automatic checkOutput(input string name);
    int exp_v;
    int act_v;
    exp_v = (m_lock == LOCK_CYCLES) ? 1 : 0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (m_tick[c] != 0) exp_v += (1 << (1 + c));
      if (m_acc[c] >= MOD / 2) exp_v += (1 << (1 + NUM_CH + c));
    end
    act_v = int'({clk_out, tick, locked});
    checkValue(name, act_v, exp_v);
  endtask

  // Drive one cycle of inputs, let the edge happen, update model, compare
  task automatic applyStimulus(input int wr, input int ch, input int inc, input int phase,
                               input int en, input int sync);
    cfg_wr    = (wr != 0);
    cfg_ch    = ch[CH_W-1:0];
    cfg_inc   = inc[ACC_W-1:0];
    cfg_phase = phase[ACC_W-1:0];
    cfg_en    = (en != 0);
    sync_load = (sync != 0);
    @(posedge refclk);
    if (rst) modelReset();
    else modelStep(wr, ch, inc, phase, en, sync);
    @(negedge refclk);
    checkOutput("model");
    cfg_wr    = 1'b0;
    sync_load = 1'b0;
  endtask

  initial begin
    int ticks;
    int high;
    int bad;
    int last;
    int found;
    int t1 [16];
    int t2 [16];

    vec_tbl[0] = '{ch:0, inc:64,  phase:0,   en:1, cycles:16, exp_ticks:4,  exp_high:8};
    vec_tbl[1] = '{ch:1, inc:96,  phase:0,   en:1, cycles:16, exp_ticks:6,  exp_high:8};
    vec_tbl[2] = '{ch:2, inc:0,   phase:200, en:1, cycles:16, exp_ticks:0,  exp_high:16};
    vec_tbl[3] = '{ch:0, inc:64,  phase:64,  en:0, cycles:16, exp_ticks:0,  exp_high:0};
    vec_tbl[4] = '{ch:1, inc:255, phase:0,   en:1, cycles:16, exp_ticks:15, exp_high:16};

    rst = 1'b1;
    cfg_wr = 1'b0; cfg_ch = '0; cfg_inc = '0; cfg_phase = '0; cfg_en = 1'b0; sync_load = 1'b0;
    modelReset();

    // Reset held for three edges, outputs all zero throughout
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkValue("reset_outputs", int'({clk_out, tick, locked}), 0);
    end
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkValue("lock_after_reset", int'(locked), (k == 4) ? 1 : 0);
      checkValue("no_tick_idle", int'(tick), 0);
    end

    // Table vectors: program one channel, count ticks and high cycles
    for (int v = 0; v < 5; v++) begin
      applyStimulus(1, vec_tbl[v].ch, vec_tbl[v].inc, vec_tbl[v].phase, vec_tbl[v].en, 0);
      ticks = 0; high = 0;
      for (int k = 0; k < vec_tbl[v].cycles; k++) begin
        applyStimulus(0, 0, 0, 0, 0, 0);
        ticks += int'(tick[vec_tbl[v].ch]);
        high  += int'(clk_out[vec_tbl[v].ch]);
      end
      checkValue($sformatf("tbl%0d_ticks", v), ticks, vec_tbl[v].exp_ticks);
      checkValue($sformatf("tbl%0d_high", v), high, vec_tbl[v].exp_high);
    end

    // Fractional rate: 96/256 gives 9 ticks in 24 cycles with gaps of 2 or 3
    applyStimulus(1, 1, 96, 0, 1, 0);
    ticks = 0; bad = 0; last = -1;
    for (int k = 0; k < 24; k++) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      if (tick[1]) begin
        if (last >= 0 && (k - last) != 2 && (k - last) != 3) bad++;
        last = k;
        ticks++;
      end
    end
    checkValue("frac_ticks", ticks, 9);
    checkValue("frac_gaps", bad, 0);

    // Phase align: ch1 starts half a turn ahead, so it leads ch2 by 2 cycles
    applyStimulus(1, 1, 64, 128, 1, 0);
    applyStimulus(1, 2, 64, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    ticks = 0; bad = 0;
    for (int k = 0; k < 16; k++) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      t1[k] = int'(tick[1]); t2[k] = int'(tick[2]);
      ticks += t2[k];
    end
    for (int k = 2; k < 16; k++) if (t2[k] != t1[k-2]) bad++;
    checkValue("align2_ticks", ticks, 4);
    checkValue("align2_lead", bad, 0);

    // sync_load plus a write of phase 64 to ch2 narrows the lead to 1 cycle
    applyStimulus(1, 2, 64, 64, 1, 1);
    ticks = 0; bad = 0;
    for (int k = 0; k < 16; k++) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      t1[k] = int'(tick[1]); t2[k] = int'(tick[2]);
      ticks += t2[k];
    end
    for (int k = 1; k < 16; k++) if (t2[k] != t1[k-1]) bad++;
    checkValue("align1_ticks", ticks, 4);
    checkValue("align1_lead", bad, 0);

    // Lock: a valid write drops locked for exactly four samples
    checkValue("locked_before_write", int'(locked), 1);
    applyStimulus(1, 0, 64, 0, 1, 0);
    checkValue("lock_drop", int'(locked), 0);
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkValue("lock_recover", int'(locked), (k == 4) ? 1 : 0);
    end
    applyStimulus(1, 3, 17, 99, 0, 0);
    checkValue("invalid_write_locked", int'(locked), 1);

    // Disabling a channel freezes its clock and silences its tick
    applyStimulus(1, 0, 64, 200, 0, 0);
    ticks = 0; high = 0;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      ticks += int'(tick[0]);
      high  += int'(clk_out[0]);
    end
    checkValue("disable_ticks", ticks, 0);
    checkValue("disable_high", high, 8);

    // Randomised traffic against the model
    for (int k = 0; k < 300; k++) begin
      applyStimulus(($urandom_range(0, 3) == 0) ? 1 : 0, $urandom_range(0, 3),
                    $urandom_range(0, 255), $urandom_range(0, 255),
                    $urandom_range(0, 1), ($urandom_range(0, 7) == 0) ? 1 : 0);
    end

    // Reset mid-run while tick[0] is high
    applyStimulus(1, 0, 64, 0, 1, 0);
    found = 0;
    for (int k = 0; k < 8 && found == 0; k++) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      if (tick[0]) found = 1;
    end
    checkValue("tick_seen_before_reset", found, 1);
    #2 rst = 1'b1;
    #1 checkValue("async_reset_outputs", int'({clk_out, tick, locked}), 0);
    modelReset();
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    ticks = 0;
    for (int k = 0; k < 10; k++) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      ticks += int'(tick[0]) + int'(tick[1]) + int'(tick[2]);
    end
    checkValue("no_ticks_after_reset", ticks, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
